// File: rtl/sequential_matrix_multiplier.sv
// sequential_matrix_multiplier
//   Computes C = A x B for square N x N matrices, one multiply-accumulate per
//   clock. Operands are fetched from an external store through registered
//   read addresses; each finished element is presented on a strobe/ack
//   handshake in row-major order.
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous reset, active low
//   start           level request to begin one multiplication
//   a_in, b_in      A[a_i][a_j] and B[b_i][b_j], returned combinationally
//   z_ack           acknowledge of the presented result element
//   a_i,a_j,b_i,b_j registered read addresses for A and B
//   z_out,z_i,z_j   result element value and its row/column
//   z_stb           result valid strobe, held until acknowledged
//   done            whole product delivered; held while start stays high
module sequential_matrix_multiplier #(
  parameter int N  = 4,
  parameter int IW = 2,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  input  logic          z_ack,
  output logic [IW-1:0] a_i,
  output logic [IW-1:0] a_j,
  output logic [IW-1:0] b_i,
  output logic [IW-1:0] b_j,
  output logic [DW-1:0] z_out,
  output logic [IW-1:0] z_i,
  output logic [IW-1:0] z_j,
  output logic          z_stb,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUTPUT,
    DONE
  } state_t;

  localparam logic [IW-1:0] LAST  = IW'(N - 1);
  // k runs 0..N; k == N is the extra cycle that publishes the finished sum,
  // so it carries one bit more than the address fields.
  localparam logic [IW:0]   K_END = (IW + 1)'(N);

  state_t        state_q, state_d;
  logic [IW-1:0] i_q, i_d, j_q, j_d;
  logic [IW:0]   k_q, k_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] prod;

  logic [DW-1:0] z_out_d;
  logic [IW-1:0] z_i_d, z_j_d;
  logic          z_stb_d, done_d;
  logic [IW-1:0] a_i_d, a_j_d, b_i_d, b_j_d;

  // Product truncated to DW bits: low bits are identical for signed and
  // unsigned operands, giving two's-complement modulo-2^DW arithmetic.
  always_comb begin
    prod = a_in * b_in;
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_d   = acc_q;
    z_out_d = z_out;
    z_i_d   = z_i;
    z_j_d   = z_j;
    z_stb_d = z_stb;
    done_d  = done;

    unique case (state_q)
      IDLE: begin
        z_stb_d = 1'b0;
        done_d  = 1'b0;
        if (start) begin
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = MAC;
        end
      end

      MAC: begin
        if (k_q != K_END) begin
          acc_d = (k_q == '0) ? prod : acc_q + prod;
          k_d   = k_q + 1'b1;
        end else begin
          z_out_d = acc_q;
          z_i_d   = i_q;
          z_j_d   = j_q;
          z_stb_d = 1'b1;
          k_d     = '0;
          state_d = OUTPUT;
        end
      end

      OUTPUT: begin
        if (z_ack) begin
          z_stb_d = 1'b0;
          if (i_q == LAST && j_q == LAST) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            if (j_q == LAST) begin
              j_d = '0;
              i_d = i_q + 1'b1;
            end else begin
              j_d = j_q + 1'b1;
            end
            k_d     = '0;
            state_d = MAC;
          end
        end
      end

      DONE: begin
        z_stb_d = 1'b0;
        done_d  = 1'b1;
        if (!start) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Addresses are registered from the next-cycle indices so the operands
    // arrive in the same cycle the MAC consumes them. Outside MAC they park
    // at zero and stay put while a result waits for acknowledge.
    if (state_d == MAC) begin
      a_i_d = i_d;
      a_j_d = k_d[IW-1:0];
      b_i_d = k_d[IW-1:0];
      b_j_d = j_d;
    end else begin
      a_i_d = '0;
      a_j_d = '0;
      b_i_d = '0;
      b_j_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      z_out   <= '0;
      z_i     <= '0;
      z_j     <= '0;
      z_stb   <= 1'b0;
      done    <= 1'b0;
      a_i     <= '0;
      a_j     <= '0;
      b_i     <= '0;
      b_j     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      z_out   <= z_out_d;
      z_i     <= z_i_d;
      z_j     <= z_j_d;
      z_stb   <= z_stb_d;
      done    <= done_d;
      a_i     <= a_i_d;
      a_j     <= a_j_d;
      b_i     <= b_i_d;
      b_j     <= b_j_d;
    end
  end

endmodule

// File: tb/tb_sequential_matrix_multiplier.sv
// tb_sequential_matrix_multiplier
//   Directed bench for sequential_matrix_multiplier (N=4, DW=32). The bench
//   plays the operand store (A and B arrays read through the DUT addresses)
//   and the result consumer (z_ack), and checks every strobed element
//   against hand-derived values.
module tb_sequential_matrix_multiplier;

  logic        clk;
  logic        rst;
  logic        start;
  logic        z_ack;
  logic [31:0] a_in, b_in;
  logic [1:0]  a_i, a_j, b_i, b_j;
  logic [31:0] z_out;
  logic [1:0]  z_i, z_j;
  logic        z_stb;
  logic        done;

  logic [31:0] ma    [4][4];
  logic [31:0] mb    [4][4];
  logic [31:0] exp_c [4][4];

  int n_cmp = 0;
  int n_bad = 0;

  sequential_matrix_multiplier #(.N(4), .IW(2), .DW(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .z_ack (z_ack),
    .a_i   (a_i),
    .a_j   (a_j),
    .b_i   (b_i),
    .b_j   (b_j),
    .z_out (z_out),
    .z_i   (z_i),
    .z_j   (z_j),
    .z_stb (z_stb),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    a_in = ma[a_i][a_j];
    b_in = mb[b_i][b_j];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected summary before 200000ns");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_stb(input string tag);
    int c = 0;
    while (z_stb !== 1'b1 && c < 40) begin
      tick();
      c++;
    end
    chk({tag, "_stb_wait"}, 32'(z_stb), 32'd1);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_stb"},  32'(z_stb), 32'd0);
    chk({tag, "_done"}, 32'(done),  32'd0);
    chk({tag, "_zout"}, z_out,      32'd0);
    chk({tag, "_zij"},  32'({z_i, z_j}), 32'd0);
    chk({tag, "_addr"}, 32'({a_i, a_j, b_i, b_j}), 32'd0);
  endtask

  // Consume all 16 results of a run (already started unless launch=1) and
  // walk through DONE back to IDLE. hold0 stalls the first acknowledge.
  task automatic run_check(input bit launch, input bit hold0, input string name);
    logic [31:0] z0;
    logic [7:0]  addr0;
    if (launch) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    for (int e = 0; e < 16; e++) begin
      int r = e / 4;
      int c = e % 4;
      string t = $sformatf("%s_%0d%0d", name, r, c);
      wait_stb(t);
      chk({t, "_zi"},   32'(z_i), 32'(r));
      chk({t, "_zj"},   32'(z_j), 32'(c));
      chk({t, "_zout"}, z_out,    exp_c[r][c]);
      if (hold0 && e == 0) begin
        z0    = z_out;
        addr0 = {a_i, a_j, b_i, b_j};
        for (int h = 0; h < 5; h++) begin
          tick();
          chk({t, "_hold_stb"},  32'(z_stb), 32'd1);
          chk({t, "_hold_zout"}, z_out, z0);
          chk({t, "_hold_zij"},  32'({z_i, z_j}), 32'd0);
          chk({t, "_hold_addr"}, 32'({a_i, a_j, b_i, b_j}), 32'(addr0));
        end
      end
      z_ack = 1'b1;
      tick();
      z_ack = 1'b0;
      chk({t, "_stb_drop"}, 32'(z_stb), 32'd0);
    end
    chk({name, "_done"},      32'(done), 32'd1);
    chk({name, "_zout_hold"}, z_out, exp_c[3][3]);
    start = 1'b1;
    tick();
    tick();
    chk({name, "_done_held"}, 32'(done),  32'd1);
    chk({name, "_done_stb"},  32'(z_stb), 32'd0);
    start = 1'b0;
    tick();
    chk({name, "_idle_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    z_ack = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ma[r][c] = '0;
        mb[r][c] = '0;
      end

    // Reset state
    repeat (3) tick();
    chk_zero_outputs("reset");
    rst = 1'b1;
    tick();

    // Identity x B: C equals B, B[r][c] = 4r+c+1
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ma[r][c]    = (r == c) ? 32'd1 : 32'd0;
        mb[r][c]    = 32'(4 * r + c + 1);
        exp_c[r][c] = 32'(4 * r + c + 1);
      end

    // z_ack high while IDLE has no effect
    z_ack = 1'b1;
    tick();
    tick();
    chk_zero_outputs("idle_ack");

    // Start sampled at edge 0; strobe first visible after edge 5.
    // z_ack stays high through edges 1..4 (MAC) and must be ignored.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("lat_e0_stb", 32'(z_stb), 32'd0);
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk($sformatf("lat_e%0d_stb", e), 32'(z_stb), 32'd0);
    end
    z_ack = 1'b0;
    tick();
    chk("lat_e5_stb", 32'(z_stb), 32'd1);
    chk("lat_e5_zout", z_out, 32'd1);
    run_check(1'b0, 1'b0, "ident");

    // All 2 x all 3: 4*6 = 24, with a stalled first acknowledge
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ma[r][c] = 32'd2;  mb[r][c] = 32'd3;  exp_c[r][c] = 32'h18;
      end
    run_check(1'b1, 1'b1, "x23");

    // All -1 x all 1: -4
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ma[r][c] = 32'hFFFF_FFFF;  mb[r][c] = 32'd1;  exp_c[r][c] = 32'hFFFF_FFFC;
      end
    run_check(1'b1, 1'b0, "neg");

    // 0x80000000 * 2 wraps to zero; everything else zero
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ma[r][c] = '0;  mb[r][c] = '0;  exp_c[r][c] = '0;
      end
    ma[0][0] = 32'h8000_0000;
    mb[0][0] = 32'd2;
    run_check(1'b1, 1'b0, "wrap");

    // A[r][c]=r+c, B[r][c]=c+1: C[r][c] = (c+1)*sum_k(r+k) = (c+1)*(4r+6)
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ma[r][c]    = 32'(r + c);
        mb[r][c]    = 32'(c + 1);
        exp_c[r][c] = 32'((c + 1) * (4 * r + 6));
      end

    // Abort during MAC of element (1,2)
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 0; e < 6; e++) begin
      wait_stb($sformatf("pre_%0d", e));
      chk($sformatf("pre_%0d_zout", e), z_out, exp_c[e / 4][e % 4]);
      z_ack = 1'b1;
      tick();
      z_ack = 1'b0;
    end
    tick();
    tick();
    chk("mid_mac_addr_ai", 32'(a_i), 32'd1);
    chk("mid_mac_addr_bj", 32'(b_j), 32'd2);
    #3 rst = 1'b0;
    #1;
    chk_zero_outputs("async_rst");
    tick();
    tick();
    rst = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      chk($sformatf("post_rst_nostb_%0d", e), 32'(z_stb), 32'd0);
    end
    chk_zero_outputs("post_rst_idle");

    // start already high when reset releases: run begins at the first edge
    rst = 1'b0;
    tick();
    start = 1'b1;
    rst   = 1'b1;
    tick();
    start = 1'b0;
    chk("rel_start_addr", 32'({a_i, a_j, b_i, b_j}), 32'd0);
    run_check(1'b0, 1'b0, "rstrun");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
